// File: rtl/hash_core_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-block hash core among NREQ requesters.
// Owner's block is captured at grant; a watchdog aborts a transaction if the core stalls.
module hash_core_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned BLK_W   = 512,
  parameter int unsigned DIG_W   = 256,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ*BLK_W-1:0] blk_i,
  output logic [NREQ-1:0]       grant_o,
  output logic [NREQ-1:0]       done_o,
  output logic                  done_err_o,
  output logic [DIG_W-1:0]      digest_o,
  output logic [2:0]            cur_id_o,
  output logic                  busy_o,
  output logic                  timeout_err_o,
  output logic [BLK_W-1:0]      core_blk_o,
  output logic                  core_start_o,
  input  logic [DIG_W-1:0]      core_digest_i,
  input  logic                  core_done_i
);

  localparam int unsigned WdW = $clog2(TIMEOUT);
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);
  localparam logic [2:0] LastId = 3'(NREQ - 1);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StWait    = 2'd1;
  localparam logic [1:0] StRelease = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [2:0]       rr_q, rr_d;
  logic [WdW-1:0]   wd_q, wd_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic             done_err_q, done_err_d;
  logic [DIG_W-1:0] digest_q, digest_d;
  logic [2:0]       cur_id_q, cur_id_d;
  logic             timeout_err_q, timeout_err_d;
  logic [BLK_W-1:0] core_blk_q, core_blk_d;
  logic             core_start_q, core_start_d;

  logic [2:0]       pick_id;
  logic [NREQ-1:0]  pick_oh;
  logic [BLK_W-1:0] pick_blk;
  int               best_dist;

  // Winner is the set request with the smallest forward distance from the rr pointer.
  always_comb begin
    pick_id   = '0;
    pick_oh   = '0;
    pick_blk  = '0;
    best_dist = int'(NREQ);
    for (int i = 0; i < int'(NREQ); i++) begin
      if (req_i[i] && (((i + int'(NREQ) - int'(rr_q)) % int'(NREQ)) < best_dist)) begin
        best_dist  = (i + int'(NREQ) - int'(rr_q)) % int'(NREQ);
        pick_id    = 3'(i);
        pick_oh    = '0;
        pick_oh[i] = 1'b1;
        pick_blk   = blk_i[i*BLK_W +: BLK_W];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    wd_d          = wd_q;
    grant_d       = grant_q;
    done_d        = '0;
    done_err_d    = 1'b0;
    digest_d      = digest_q;
    cur_id_d      = cur_id_q;
    timeout_err_d = timeout_err_q;
    core_blk_d    = core_blk_q;
    core_start_d  = core_start_q;
    case (state_q)
      StIdle: begin
        if (|req_i) begin
          core_blk_d   = pick_blk;
          grant_d      = pick_oh;
          cur_id_d     = pick_id;
          core_start_d = 1'b1;
          wd_d         = '0;
          state_d      = StWait;
        end
      end
      StWait: begin
        // A completion in the expiry cycle still counts as a normal finish.
        if (core_done_i) begin
          digest_d     = core_digest_i;
          done_d       = grant_q;
          core_start_d = 1'b0;
          state_d      = StRelease;
        end else if (wd_q == WdLast) begin
          digest_d      = '0;
          done_d        = grant_q;
          done_err_d    = 1'b1;
          timeout_err_d = 1'b1;
          core_start_d  = 1'b0;
          state_d       = StRelease;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      StRelease: begin
        grant_d = '0;
        rr_d    = (cur_id_q == LastId) ? 3'd0 : cur_id_q + 3'd1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      rr_q          <= '0;
      wd_q          <= '0;
      grant_q       <= '0;
      done_q        <= '0;
      done_err_q    <= 1'b0;
      digest_q      <= '0;
      cur_id_q      <= '0;
      timeout_err_q <= 1'b0;
      core_blk_q    <= '0;
      core_start_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      wd_q          <= wd_d;
      grant_q       <= grant_d;
      done_q        <= done_d;
      done_err_q    <= done_err_d;
      digest_q      <= digest_d;
      cur_id_q      <= cur_id_d;
      timeout_err_q <= timeout_err_d;
      core_blk_q    <= core_blk_d;
      core_start_q  <= core_start_d;
    end
  end

  assign grant_o       = grant_q;
  assign done_o        = done_q;
  assign done_err_o    = done_err_q;
  assign digest_o      = digest_q;
  assign cur_id_o      = cur_id_q;
  assign busy_o        = (state_q != StIdle);
  assign timeout_err_o = timeout_err_q;
  assign core_blk_o    = core_blk_q;
  assign core_start_o  = core_start_q;

endmodule

// File: tb/tb_hash_core_arbiter.sv
// Bench for hash_core_arbiter: two instances (long and short watchdog) on shared inputs,
// a behavioural hash core, and a scoreboard of expected done pulses.
module tb_hash_core_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned BLK_W = 512;
  localparam int unsigned DIG_W = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]       req = '0;
  logic [BLK_W-1:0]      blk_v [NREQ];
  logic [NREQ*BLK_W-1:0] blk;
  logic [DIG_W-1:0]      core_digest;
  logic                  core_done = 1'b0;

  logic [NREQ-1:0]  a_grant, a_done, b_grant, b_done;
  logic             a_done_err, a_busy, a_terr, a_start, b_done_err, b_busy, b_terr, b_start;
  logic [DIG_W-1:0] a_digest, b_digest;
  logic [2:0]       a_cur_id, b_cur_id;
  logic [BLK_W-1:0] a_core_blk, b_core_blk;

  always_comb begin
    for (int i = 0; i < NREQ; i++) blk[i*BLK_W +: BLK_W] = blk_v[i];
  end

  hash_core_arbiter #(.NREQ(NREQ), .BLK_W(BLK_W), .DIG_W(DIG_W), .TIMEOUT(1024)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .blk_i(blk),
    .grant_o(a_grant), .done_o(a_done), .done_err_o(a_done_err), .digest_o(a_digest),
    .cur_id_o(a_cur_id), .busy_o(a_busy), .timeout_err_o(a_terr),
    .core_blk_o(a_core_blk), .core_start_o(a_start),
    .core_digest_i(core_digest), .core_done_i(core_done)
  );

  hash_core_arbiter #(.NREQ(NREQ), .BLK_W(BLK_W), .DIG_W(DIG_W), .TIMEOUT(16)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .blk_i(blk),
    .grant_o(b_grant), .done_o(b_done), .done_err_o(b_done_err), .digest_o(b_digest),
    .cur_id_o(b_cur_id), .busy_o(b_busy), .timeout_err_o(b_terr),
    .core_blk_o(b_core_blk), .core_start_o(b_start),
    .core_digest_i(core_digest), .core_done_i(core_done)
  );

  // The instance under observation drives the core model and the scoreboard.
  logic             use_b = 1'b0;
  logic [NREQ-1:0]  s_grant, s_done;
  logic             s_done_err, s_busy, s_terr, s_start;
  logic [DIG_W-1:0] s_digest;
  logic [2:0]       s_cur_id;
  logic [BLK_W-1:0] s_core_blk;
  assign s_grant    = use_b ? b_grant    : a_grant;
  assign s_done     = use_b ? b_done     : a_done;
  assign s_done_err = use_b ? b_done_err : a_done_err;
  assign s_busy     = use_b ? b_busy     : a_busy;
  assign s_terr     = use_b ? b_terr     : a_terr;
  assign s_start    = use_b ? b_start    : a_start;
  assign s_digest   = use_b ? b_digest   : a_digest;
  assign s_cur_id   = use_b ? b_cur_id   : a_cur_id;
  assign s_core_blk = use_b ? b_core_blk : a_core_blk;

  // Toy hash: fold the two halves of the block together.
  assign core_digest = s_core_blk[BLK_W-1:DIG_W] ^ s_core_blk[DIG_W-1:0];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [DIG_W-1:0] got,
                          input logic [DIG_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [NREQ-1:0]  done;
    logic             err;
    logic [DIG_W-1:0] dig;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  function automatic logic [DIG_W-1:0] dig_of(input int i);
    logic [BLK_W-1:0] b;
    b = blk_v[i];
    return b[BLK_W-1:DIG_W] ^ b[DIG_W-1:0];
  endfunction

  task automatic push(input int i, input logic err, input logic [DIG_W-1:0] dig);
    exp_t e;
    e.done = NREQ'(1) << i;
    e.err  = err;
    e.dig  = dig;
    sb.push_back(e);
  endtask

  // Core model: done pulse core_lat cycles after start rises, unless never_done.
  int core_lat = 5;
  bit never_done = 1'b0;
  int lat_cnt = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (s_start && !never_done) begin
        core_done = (lat_cnt == core_lat - 1);
        lat_cnt++;
      end else begin
        core_done = 1'b0;
        lat_cnt = 0;
      end
    end
  end

  // Monitor: scoreboard on done pulses, requesters drop req after done, start-gap check.
  logic [NREQ-1:0] hold = '0;
  int  low_cnt = 0;
  bit  seen_start = 1'b0;
  logic prev_start = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (s_done != '0) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_done", DIG_W'(s_done), '0);
        end else begin
          mon_e = sb.pop_front();
          check_eq("done_vec", DIG_W'(s_done), DIG_W'(mon_e.done));
          check_eq("done_err", DIG_W'(s_done_err), DIG_W'(mon_e.err));
          check_eq("digest", s_digest, mon_e.dig);
          check_eq("grant_at_done", DIG_W'(s_grant), DIG_W'(mon_e.done));
        end
        req = req & ~(s_done & ~hold);
      end
      if (!rst_n) begin
        seen_start = 1'b0;
        low_cnt = 0;
      end else if (s_start && !prev_start) begin
        if (seen_start) check_eq("start_gap_ge2", DIG_W'(low_cnt >= 2), DIG_W'(1));
        seen_start = 1'b1;
        low_cnt = 0;
      end else if (!s_start) begin
        low_cnt++;
      end
      prev_start = s_start;
    end
  end

  task automatic do_reset(input logic sel_b);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    req = '0;
    hold = '0;
    never_done = 1'b0;
    use_b = sel_b;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq("drain_queue_empty", DIG_W'(sb.size()), '0);
    sb.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    blk_v[0] = {256'h0, {32{8'hAB}}};
    for (int i = 1; i < NREQ; i++) begin
      blk_v[i] = {{8{32'hC0DE_0000 + 32'(i)}}, {8{32'h1357_9BDF ^ (32'(i) << 8)}}};
    end

    // 1: single requester, latency 20, reset values first.
    do_reset(1'b0);
    check_eq("rst_grant", DIG_W'(a_grant), '0);
    check_eq("rst_done", DIG_W'(a_done), '0);
    check_eq("rst_busy", DIG_W'(a_busy), '0);
    check_eq("rst_digest", a_digest, '0);
    check_eq("rst_core_blk", a_core_blk[DIG_W-1:0] | a_core_blk[BLK_W-1:DIG_W], '0);
    check_eq("rst_start_terr_cur", DIG_W'({a_core_blk == '0, a_start, a_terr, a_cur_id}), '0 | (DIG_W'(1) << 5));
    core_lat = 20;
    req = 4'b0001;
    check_eq("t1_start_before_edge", DIG_W'(a_start), '0);
    @(negedge clk);
    #1;
    check_eq("t1_start_t1", DIG_W'(a_start), DIG_W'(1));
    check_eq("t1_grant", DIG_W'(a_grant), DIG_W'(4'b0001));
    check_eq("t1_core_blk_lo", a_core_blk[DIG_W-1:0], {32{8'hAB}});
    check_eq("t1_busy", DIG_W'(a_busy), DIG_W'(1));
    push(0, 1'b0, {32{8'hAB}});
    blk_v[0] = ~blk_v[0];
    drain(40);
    @(negedge clk);
    #1;
    check_eq("t1_grant_idle", DIG_W'(a_grant), '0);
    check_eq("t1_busy_idle", DIG_W'(a_busy), '0);
    check_eq("t1_digest_held", a_digest, {32{8'hAB}});
    blk_v[0] = ~blk_v[0];

    // 2: all four request, served in index order.
    do_reset(1'b0);
    core_lat = 5;
    for (int i = 0; i < NREQ; i++) push(i, 1'b0, dig_of(i));
    req = 4'b1111;
    drain(200);

    // 3: req0 and req2 keep re-requesting; must alternate.
    do_reset(1'b0);
    hold = 4'b0101;
    for (int k = 0; k < 2; k++) begin
      push(0, 1'b0, dig_of(0));
      push(2, 1'b0, dig_of(2));
    end
    req = 4'b0101;
    drain(200);
    req = '0;
    hold = '0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("t3_idle_grant", DIG_W'(a_grant), '0);

    // 4: stalled core on the TIMEOUT=16 instance, then a healthy transaction.
    do_reset(1'b1);
    never_done = 1'b1;
    req = 4'b0100;
    @(negedge clk);
    #1;
    check_eq("t4_start", DIG_W'(b_start), DIG_W'(1));
    push(2, 1'b1, '0);
    repeat (15) @(negedge clk);
    #1;
    check_eq("t4_no_early_done", DIG_W'(b_done), '0);
    check_eq("t4_terr_before", DIG_W'(b_terr), '0);
    drain(3);
    check_eq("t4_terr_set", DIG_W'(b_terr), DIG_W'(1));
    @(negedge clk);
    #1;
    never_done = 1'b0;
    core_lat = 5;
    push(0, 1'b0, dig_of(0));
    req = 4'b0001;
    drain(40);
    check_eq("t4_terr_sticky", DIG_W'(b_terr), DIG_W'(1));

    // 6: core_done in the watchdog expiry cycle is a normal completion.
    do_reset(1'b1);
    core_lat = 16;
    push(1, 1'b0, dig_of(1));
    req = 4'b0010;
    drain(40);
    check_eq("t6_terr_clear", DIG_W'(b_terr), '0);

    // 5: reset three cycles into WAIT, rr pointer must restart at 0.
    do_reset(1'b0);
    core_lat = 5;
    push(0, 1'b0, dig_of(0));
    req = 4'b0001;
    drain(40);
    @(negedge clk);
    #1;
    never_done = 1'b1;
    req = 4'b0100;
    repeat (3) @(negedge clk);
    #1;
    check_eq("t5_busy_pre", DIG_W'(a_busy), DIG_W'(1));
    rst_n = 1'b0;
    #1;
    check_eq("t5_grant_async", DIG_W'(a_grant), '0);
    check_eq("t5_start_async", DIG_W'(a_start), '0);
    check_eq("t5_busy_async", DIG_W'(a_busy), '0);
    check_eq("t5_done_async", DIG_W'(a_done), '0);
    req = '0;
    never_done = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    push(0, 1'b0, dig_of(0));
    push(2, 1'b0, dig_of(2));
    req = 4'b0101;
    drain(100);
    @(negedge clk);
    #1;
    push(1, 1'b0, dig_of(1));
    req = 4'b0010;
    drain(40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hash_core_arbiter.md
Name: hash_core_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one single-block hash core (512-bit block in, 256-bit digest out, level start / done-pulse handshake) among NREQ requesters in the Picnic signing datapath, e.g. commitment hashing, HCP challenge hashing and seed expansion.
- Latches the winning requester's block, holds core start until done, returns the digest with a one-cycle done pulse to that requester.
- Runs a watchdog so a stalled core cannot hang the signer.

Parameters:
NREQ, 4, number of requesters (2..8)
BLK_W, 512, hash input block width
DIG_W, 256, digest width
TIMEOUT, 1024, max cycles in WAIT before abort (>=2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req  in  NREQ  per-requester level request; held until own done pulse
blk  in  NREQ*BLK_W  requester blocks, requester i at [i*BLK_W +: BLK_W]
grant  out  NREQ  one-hot, current owner; 0 when idle
done  out  NREQ  one-cycle pulse to owner when its transaction ends
done_err  out  1  high with done pulse if the transaction timed out
digest  out  DIG_W  result register, valid from done pulse until next done
cur_id  out  3  index of current/last owner
busy  out  1  high in WAIT and RELEASE
timeout_err  out  1  sticky, set on any timeout, cleared only by reset
core_blk  out  BLK_W  registered block to hash core
core_start  out  1  level start to hash core
core_digest  in  DIG_W  hash core result
core_done  in  1  hash core completion (sampled; may be pulse or level)

Behaviour:
- Reset (async, reset=0): all outputs 0, state IDLE, rr pointer 0, watchdog 0.
- States: IDLE, WAIT, RELEASE.
- IDLE:
  - If req!=0, pick the first set bit at or after rr pointer, wrapping modulo NREQ.
  - Register core_blk <= blk[id], grant <= onehot(id), cur_id <= id, core_start <= 1, watchdog <= 0; go WAIT.
  - req at cycle t produces core_start high at t+1.
- WAIT:
  - core_start stays 1 and grant stays stable; watchdog increments each cycle.
  - core_done=1: digest <= core_digest; done[cur_id] pulses next cycle; done_err=0; core_start <= 0; go RELEASE.
  - watchdog==TIMEOUT-1 with no core_done: core_start <= 0, digest <= 0, done[cur_id] and done_err pulse, timeout_err <= 1; go RELEASE.
  - core_done and timeout in the same cycle: core_done wins, no error.
- RELEASE:
  - Exactly one cycle: grant <= 0, core_start low, rr pointer <= (cur_id+1) mod NREQ; go IDLE.
  - Guarantees core_start is low for at least 2 cycles between transactions, so a level-sensitive core re-arms.
- Requester rule: drop req within one cycle after its done. A req still high when IDLE is next evaluated is served as a new transaction, subject to rr order.
- The block is captured at grant; changes to blk or req of the owner during WAIT are ignored.
- core_done seen in IDLE or RELEASE is ignored.
- Fairness: with all requesters continuously requesting, service order is 0,1,...,NREQ-1,0,... and no requester waits more than NREQ-1 transactions.
- done, done_err and grant are registered outputs (no combinational path from req or core_done).
- Reset mid-transaction: immediate abort, no done pulse, core_start drops asynchronously.

Test Plan:
1. req=0001, core returns done 20 cycles after start with digest 0xAB..AB -> core_start high at t+1, core_blk=blk[0], done=0001 for one cycle, digest=0xAB..AB, done_err=0, grant back to 0 after RELEASE.
2. req=1111 held, each requester drops req after its done, core latency 5 -> grants in order 0001,0010,0100,1000; core_start low ≥2 cycles between transactions.
3. req0 held continuously (re-requests) plus req2 asserted -> grants alternate 0,2,0,2 and req2 is never skipped.
4. TIMEOUT=16, core never asserts done, req=0100 -> after 16 WAIT cycles done=0100 with done_err=1, digest=0, timeout_err stays 1; a following transaction with a healthy core completes with done_err=0 while timeout_err remains 1.
5. reset pulled low 3 cycles into WAIT -> grant, core_start, busy go 0 immediately, no done pulse; after release, rr pointer 0 and req=0010 is served normally.
6. core_done asserted in the same cycle the watchdog expires -> normal completion, digest=core_digest, done_err=0, timeout_err=0.
